gas_pattern_detector: RTL and testbench
=======================================

# gas_pattern_detector

Parametrised multi-channel serial pattern detector for the gas sensor path. It generalises the fixed-sequence methane and CO detectors into NUM_PAT independently programmable patterns of up to MAX_LEN bits each. Each pattern has selectable overlap mode, a saturating hit counter and a threshold-driven sticky alarm. It sits between the sensor bit stream and the alarm/display logic.

## Interface
- NUM_PAT, 3, number of independent patterns (1..8)
- MAX_LEN, 16, maximum pattern length in bits (2..32)
- CNT_W, 8, hit counter width per pattern
- ALARM_TH, 1, hit count at which alarm sets (1..2^CNT_W-1)
- SEL_W, 2, width of cfg_sel; must satisfy 2^SEL_W >= NUM_PAT
- LEN_W, 5, width of cfg_len; must hold MAX_LEN

- clk  in  1  clock, all logic on posedge
- arst  in  1  reset, synchronous, active-low: sampled on posedge clk; 0 resets the block
- din_valid  in  1  din qualifier; a bit is accepted only on edges with din_valid=1
- din  in  1  serial sensor bit
- cfg_we  in  1  config write strobe
- cfg_sel  in  SEL_W  pattern index to write
- cfg_pattern  in  MAX_LEN  pattern bits; bit 0 = most recent bit, bit len-1 = oldest
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = restart after match
- cfg_en  in  1  pattern enable
- alarm_clr  in  NUM_PAT  per-pattern clear of alarm and hit counter
- match  out  NUM_PAT  one-cycle pulse per detected occurrence
- alarm  out  NUM_PAT  sticky alarm
- hit_cnt  out  NUM_PAT*CNT_W  saturating hit counters, pattern i at [i*CNT_W +: CNT_W]

## Operation
- Shared history: hist (MAX_LEN bits); on accepted bit, hist <= {hist[MAX_LEN-2:0], din}.
- Per-pattern fill counter fill_i, saturating at MAX_LEN, counts accepted bits since reset / last config write to i / last match of i in non-overlap mode.
- Candidate window for an accepted bit: w = {hist[MAX_LEN-2:0], din}. Pattern i hits when en_i=1, fill_i+1 >= len_i, and w[len_i-1:0] == pat_i[len_i-1:0].
- On hit: match[i] pulses; hit_cnt_i increments, saturating at all ones; if new count >= ALARM_TH, alarm[i] sets. If overlap_i=0, fill_i clears to 0 (current bit not reused); else fill_i increments normally.
- Config write (cfg_we=1, cfg_sel < NUM_PAT): stores pattern, len, overlap, en for cfg_sel and clears fill for that pattern. cfg_len=0 or > MAX_LEN stores en=0. cfg_sel >= NUM_PAT: write ignored. alarm and hit_cnt are not affected.
- Config write and accepted bit on the same edge: written pattern does not hit on that bit, and its fill stays 0; hist still shifts; other patterns unaffected.
- alarm_clr[i]: clears alarm[i] and hit_cnt_i. Simultaneous with hit on i: hit wins over clear; hit_cnt_i = 1, alarm[i] = (ALARM_TH == 1).
- din_valid=0: hist, fill, counters hold; match = 0.

## Timing
- Reset (arst=0 at an edge): hist, fill, all pattern registers, en, match, alarm, hit_cnt all 0. Reset overrides cfg_we, din_valid, alarm_clr.
- Match latency: bit accepted at edge k -> match[i] high for the cycle after edge k, hit_cnt/alarm updated at edge k as well.
- New configuration is active for bits accepted from the edge after the write.
- Back-to-back matches allowed every accepted bit in overlap mode (e.g. pattern 11, len 2).
- No combinational path from inputs to outputs; all outputs registered.

## Test plan
- Reset: with arst=0 for 3 edges while din_valid=1, din toggling, cfg_we=1 -> match, alarm, hit_cnt all 0. Then arst=1 and no config -> no matches for 20 random bits.
- Overlap: pattern 0 = 1011, len 4, overlap=1, en=1; stream 1,0,1,1,0,1,1 -> match[0] after bits 4 and 7, hit_cnt0=2, alarm[0]=1 (ALARM_TH=1).
- Non-overlap: same stream, overlap=0 -> single match after bit 4, hit_cnt0=1. Appending 0,1,1 gives a second match.
- Gaps and multi-pattern: pattern 1 = 11, len 2, overlap=1; stream 1,1,1 with din_valid=0 cycles between bits -> match[1] after bits 2 and 3 only, no pulses in idle cycles. Pattern 0 is unaffected.
- Threshold/clear: ALARM_TH=2; the alarm sets only on the second hit. alarm_clr[0] on the same edge as a hit -> hit_cnt0=1, alarm[0]=0.
- Saturation/edge cases: CNT_W=2 with 5 hits -> hit_cnt0=3. A cfg write with len=0 -> en=0 and no matches. A cfg write on the same edge as the completing bit -> no match. Reset mid-pattern (after 101) then 1 -> no match.

Source files
------------

// File: rtl/gas_pattern_detector.sv
// NUM_PAT programmable serial pattern matchers over one shared bit history. Each has a saturating hit counter and a sticky alarm.
// Outputs update at the edge that accepts the bit, so match pulses the cycle after it. No backpressure: every valid bit is consumed.
module gas_pattern_detector #(
  parameter int NUM_PAT  = 3,
  parameter int MAX_LEN  = 16,
  parameter int CNT_W    = 8,
  parameter int ALARM_TH = 1,
  parameter int SEL_W    = 2,
  parameter int LEN_W    = 5
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     din_valid,
  input  logic                     din,
  input  logic                     cfg_we,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     cfg_overlap,
  input  logic                     cfg_en,
  input  logic [NUM_PAT-1:0]       alarm_clr,
  output logic [NUM_PAT-1:0]       match,
  output logic [NUM_PAT-1:0]       alarm,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] TH        = CNT_W'(ALARM_TH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0]                    hist;
  logic [MAX_LEN-1:0]                    win;
  logic [NUM_PAT-1:0][MAX_LEN-1:0]       pat;
  logic [NUM_PAT-1:0][LEN_W-1:0]         len;
  logic [NUM_PAT-1:0][LEN_W-1:0]         fill;
  logic [NUM_PAT-1:0]                    ovl;
  logic [NUM_PAT-1:0]                    en;
  logic [NUM_PAT-1:0]                    wr;
  logic [NUM_PAT-1:0]                    hit;
  logic [NUM_PAT-1:0][CNT_W-1:0]         cnt;
  logic [NUM_PAT-1:0][CNT_W-1:0]         cnt_nxt;
  logic [NUM_PAT-1:0]                    alarm_nxt;
  logic                                  cfg_len_ok;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_LEN; b++) m[b] = (b < int'(l));
    return m;
  endfunction

  // The window includes the bit being accepted, so a hit is visible at that same edge.
  assign win        = {hist[MAX_LEN-2:0], din};
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  always_comb begin
    wr        = '0;
    hit       = '0;
    cnt_nxt   = cnt;
    alarm_nxt = alarm;
    for (int i = 0; i < NUM_PAT; i++) begin
      wr[i]  = cfg_we && (cfg_sel == SEL_W'(i));
      hit[i] = din_valid && !wr[i] && en[i]
               && (({1'b0, fill[i]} + (LEN_W+1)'(1)) >= {1'b0, len[i]})
               && (((win ^ pat[i]) & len_mask(len[i])) == '0);
      // A clear coinciding with a hit restarts the count at this hit.
      cnt_nxt[i]   = alarm_clr[i] ? CNT_W'(1)
                   : ((cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(1));
      alarm_nxt[i] = (cnt_nxt[i] >= TH) || (alarm[i] && !alarm_clr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      hist  <= '0;
      pat   <= '0;
      len   <= '0;
      fill  <= '0;
      ovl   <= '0;
      en    <= '0;
      cnt   <= '0;
      alarm <= '0;
      match <= '0;
    end else begin
      match <= hit;
      if (din_valid) hist <= win;
      for (int i = 0; i < NUM_PAT; i++) begin
        if (wr[i]) begin
          pat[i]  <= cfg_pattern;
          len[i]  <= cfg_len;
          ovl[i]  <= cfg_overlap;
          en[i]   <= cfg_en && cfg_len_ok;
          fill[i] <= '0;
        end else if (din_valid) begin
          if (hit[i] && !ovl[i]) fill[i] <= '0;
          else if (fill[i] < MAX_LEN_L) fill[i] <= fill[i] + LEN_W'(1);
        end
        if (hit[i]) begin
          cnt[i]   <= cnt_nxt[i];
          alarm[i] <= alarm_nxt[i];
        end else if (alarm_clr[i]) begin
          cnt[i]   <= '0;
          alarm[i] <= 1'b0;
        end
      end
    end
  end

  assign hit_cnt = cnt;

endmodule

// File: tb/tb_gas_pattern_detector.sv
// Bench for gas_pattern_detector: two instances (default, and CNT_W=2/ALARM_TH=2) share stimulus against a bit-queue reference model.
module tb_gas_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, din_valid, din, cfg_we, cfg_overlap, cfg_en;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic [2:0]  alarm_clr;
  logic [2:0]  match_a, alarm_a, match_b, alarm_b;
  logic [23:0] cnt_a;
  logic [5:0]  cnt_b;

  gas_pattern_detector dut_a (
    .clk(clk), .arst(arst), .din_valid(din_valid), .din(din), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_en(cfg_en), .alarm_clr(alarm_clr),
    .match(match_a), .alarm(alarm_a), .hit_cnt(cnt_a)
  );

  gas_pattern_detector #(.CNT_W(2), .ALARM_TH(2)) dut_b (
    .clk(clk), .arst(arst), .din_valid(din_valid), .din(din), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_en(cfg_en), .alarm_clr(alarm_clr),
    .match(match_b), .alarm(alarm_b), .hit_cnt(cnt_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: accepted bits kept as a list; a pattern is seen when enough bits
  // arrived since its last restart and the newest len bits equal it.
  int cw[2] = '{8, 2};
  int th[2] = '{1, 2};
  int m_pat[2][3], m_len[2][3], m_ovl[2][3], m_en[2][3];
  int m_since[2][3], m_cnt[2][3], m_alarm[2][3], m_match[2][3];
  int hq[$];
  int pulses[2][3];

  task automatic model_edge();
    if (!arst) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 3; i++) begin
          m_pat[d][i] = 0; m_len[d][i] = 0; m_ovl[d][i] = 0; m_en[d][i] = 0;
          m_since[d][i] = 0; m_cnt[d][i] = 0; m_alarm[d][i] = 0; m_match[d][i] = 0;
        end
      hq.delete();
      return;
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        bit wr, ok, hit;
        int b, nc, maxc;
        wr = cfg_we && (int'(cfg_sel) == i);
        ok = (m_en[d][i] != 0) && (m_since[d][i] + 1 >= m_len[d][i]);
        if (ok)
          for (int j = 0; j < m_len[d][i]; j++) begin
            b = (j == 0) ? int'(din) : hq[hq.size() - j];
            if (b != ((m_pat[d][i] >> j) & 1)) ok = 0;
          end
        hit = din_valid && !wr && ok;
        m_match[d][i] = hit;
        maxc = (1 << cw[d]) - 1;
        if (hit) begin
          nc = alarm_clr[i] ? 1 : ((m_cnt[d][i] < maxc) ? m_cnt[d][i] + 1 : maxc);
          m_cnt[d][i] = nc;
          m_alarm[d][i] = alarm_clr[i] ? int'(nc >= th[d]) : int'(m_alarm[d][i] != 0 || nc >= th[d]);
        end else if (alarm_clr[i]) begin
          m_cnt[d][i] = 0;
          m_alarm[d][i] = 0;
        end
        if (wr) begin
          m_pat[d][i] = int'(cfg_pattern);
          m_len[d][i] = int'(cfg_len);
          m_ovl[d][i] = int'(cfg_overlap);
          m_en[d][i]  = int'(cfg_en && cfg_len >= 1 && cfg_len <= 16);
          m_since[d][i] = 0;
        end else if (din_valid) begin
          m_since[d][i] = (hit && m_ovl[d][i] == 0) ? 0 : m_since[d][i] + 1;
        end
      end
    if (din_valid) begin
      hq.push_back(int'(din));
      if (hq.size() > 64) void'(hq.pop_front());
    end
  endtask

  task automatic tick(input string tag);
    logic [2:0]  em_a, ea_a, em_b, ea_b;
    logic [23:0] ec_a;
    logic [5:0]  ec_b;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      em_a[i] = m_match[0][i][0];
      ea_a[i] = m_alarm[0][i][0];
      ec_a[i*8 +: 8] = 8'(m_cnt[0][i]);
      em_b[i] = m_match[1][i][0];
      ea_b[i] = m_alarm[1][i][0];
      ec_b[i*2 +: 2] = 2'(m_cnt[1][i]);
      pulses[0][i] += int'(match_a[i]);
      pulses[1][i] += int'(match_b[i]);
    end
    check($sformatf("%s match_a", tag), 32'(match_a), 32'(em_a));
    check($sformatf("%s alarm_a", tag), 32'(alarm_a), 32'(ea_a));
    check($sformatf("%s cnt_a", tag), 32'(cnt_a), 32'(ec_a));
    check($sformatf("%s match_b", tag), 32'(match_b), 32'(em_b));
    check($sformatf("%s alarm_b", tag), 32'(alarm_b), 32'(ea_b));
    check($sformatf("%s cnt_b", tag), 32'(cnt_b), 32'(ec_b));
  endtask

  task automatic bit_in(input logic d);
    din_valid = 1'b1;
    din = d;
    tick("bit");
    din_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] bits);
    for (int k = n - 1; k >= 0; k--) bit_in(bits[k]);
  endtask

  task automatic cfg(input int sel, input logic [15:0] p, input int l, input logic o, input logic e);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_pattern = p; cfg_len = 5'(l);
    cfg_overlap = o; cfg_en = e;
    tick("cfg");
    cfg_we = 1'b0;
  endtask

  task automatic clr_all();
    alarm_clr = 3'b111;
    tick("clr");
    alarm_clr = '0;
  endtask

  task automatic zero_pulses();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) pulses[d][i] = 0;
  endtask

  initial begin
    arst = 1'b0; din_valid = 1'b0; din = 1'b0; cfg_we = 1'b0; cfg_sel = '0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_en = 1'b0; alarm_clr = '0;
    zero_pulses();

    // reset overrides config writes and valid bits
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_pattern = 16'h3; cfg_len = 5'd2;
    cfg_en = 1'b1; cfg_overlap = 1'b1; din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = k[0];
      tick("rst");
    end
    check("rst match", 32'(match_a), 32'd0);
    check("rst cnt", 32'(cnt_a), 32'd0);
    check("rst alarm", 32'(alarm_a), 32'd0);
    arst = 1'b1; cfg_we = 1'b0; din_valid = 1'b0;
    zero_pulses();
    repeat (20) bit_in(1'($urandom_range(1)));
    check("unconfigured pulses", 32'(pulses[0][0] + pulses[0][1] + pulses[0][2]), 32'd0);

    // overlapping 1011
    cfg(0, 16'hB, 4, 1'b1, 1'b1);
    zero_pulses();
    feed(7, 32'b1011011);
    check("ovl pulses", 32'(pulses[0][0]), 32'd2);
    check("ovl cnt_a", 32'(cnt_a[7:0]), 32'd2);
    check("ovl alarm_a", 32'(alarm_a[0]), 32'd1);
    check("ovl alarm_b", 32'(alarm_b[0]), 32'd1);

    // non-overlapping 1011; second instance alarms only on the second hit
    clr_all();
    cfg(0, 16'hB, 4, 1'b0, 1'b1);
    zero_pulses();
    feed(7, 32'b1011011);
    check("novl pulses", 32'(pulses[0][0]), 32'd1);
    check("novl cnt_a", 32'(cnt_a[7:0]), 32'd1);
    check("th first hit alarm_b", 32'(alarm_b[0]), 32'd0);
    feed(3, 32'b011);
    check("novl second pulses", 32'(pulses[0][0]), 32'd2);
    check("th second hit alarm_b", 32'(alarm_b[0]), 32'd1);

    // gaps between bits, second pattern
    cfg(1, 16'h3, 2, 1'b1, 1'b1);
    zero_pulses();
    bit_in(1'b1); tick("gap");
    bit_in(1'b1); tick("gap");
    bit_in(1'b1); tick("gap");
    check("gap pulses p1", 32'(pulses[0][1]), 32'd2);
    check("gap pulses p0", 32'(pulses[0][0]), 32'd0);

    // clear coinciding with a hit
    feed(3, 32'b101);
    alarm_clr = 3'b001;
    bit_in(1'b1);
    alarm_clr = '0;
    check("clr+hit cnt_a", 32'(cnt_a[7:0]), 32'd1);
    check("clr+hit alarm_a", 32'(alarm_a[0]), 32'd1);
    check("clr+hit cnt_b", 32'(cnt_b[1:0]), 32'd1);
    check("clr+hit alarm_b", 32'(alarm_b[0]), 32'd0);

    // saturation of the 2-bit counter
    clr_all();
    cfg(0, 16'h3, 2, 1'b1, 1'b1);
    feed(6, 32'b111111);
    check("sat cnt_b", 32'(cnt_b[1:0]), 32'd3);
    check("sat cnt_a", 32'(cnt_a[7:0]), 32'd5);

    // illegal lengths disable the pattern
    cfg(0, 16'h0, 0, 1'b1, 1'b1);
    cfg(2, 16'h1, 17, 1'b1, 1'b1);
    zero_pulses();
    repeat (10) bit_in(1'($urandom_range(1)));
    bit_in(1'b0); bit_in(1'b1);
    check("len0 pulses", 32'(pulses[0][0]), 32'd0);
    check("len17 pulses", 32'(pulses[0][2]), 32'd0);

    // config write on the completing bit
    cfg(0, 16'hB, 4, 1'b1, 1'b1);
    feed(3, 32'b101);
    zero_pulses();
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_pattern = 16'hB; cfg_len = 5'd4;
    cfg_overlap = 1'b1; cfg_en = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick("cfg+bit");
    cfg_we = 1'b0; din_valid = 1'b0;
    check("cfg+bit pulses", 32'(pulses[0][0]), 32'd0);

    // reset in the middle of a pattern
    feed(3, 32'b101);
    arst = 1'b0; tick("mid rst"); arst = 1'b1;
    zero_pulses();
    bit_in(1'b1);
    cfg(0, 16'hB, 4, 1'b1, 1'b1);
    bit_in(1'b1);
    check("mid rst pulses", 32'(pulses[0][0]), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      arst        = ($urandom_range(199) != 0);
      din_valid   = ($urandom_range(3) != 0);
      din         = 1'($urandom_range(1));
      cfg_we      = ($urandom_range(19) == 0);
      cfg_sel     = 2'($urandom_range(3));
      cfg_pattern = 16'($urandom_range(65535));
      cfg_len     = ($urandom_range(7) == 0) ? 5'($urandom_range(17)) : 5'($urandom_range(4, 1));
      cfg_overlap = 1'($urandom_range(1));
      cfg_en      = ($urandom_range(3) != 0);
      alarm_clr   = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'd0;
      tick("rnd");
    end
    arst = 1'b1; din_valid = 1'b0; cfg_we = 1'b0; alarm_clr = '0;
    tick("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
